// File: rtl/dct_pkg.sv
// ----------------------------------------------------------------------------
// dct_pkg
// Shared constants and types for the DCT transpose buffer.
//   DCT_N / DCT_W        : default transform size (points) and lane width (bits)
//   MODE_TRANSPOSE/BYPASS: values of the per-block mode flag
//   bank_sel_t           : selects one of the two ping-pong banks
// ----------------------------------------------------------------------------
package dct_pkg;

  localparam int DCT_N = 8;
  localparam int DCT_W = 32;

  localparam logic MODE_TRANSPOSE = 1'b0;
  localparam logic MODE_BYPASS    = 1'b1;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/dct_tb_bank.sv
// ----------------------------------------------------------------------------
// dct_tb_bank
// One N x N word bank of the ping-pong transpose buffer: row-wise write port,
// full flag, per-block mode flag and a combinational row/column read mux.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears flags only)
//   i_wr_en      : write row i_wr_data into row i_wr_row this cycle
//   i_wr_row     : destination row index
//   i_wr_data    : row vector, lane k at [k*W +: W]
//   i_mode       : mode to latch when row 0 is written
//   i_clr_full   : the final vector of this bank is being consumed
//   i_rd_idx     : index of the output vector to present
//   o_full       : bank holds a complete block
//   o_rd_data    : output vector (column in transpose mode, row in bypass)
// ----------------------------------------------------------------------------
module dct_tb_bank
  import dct_pkg::*;
#(
  parameter int N = DCT_N,
  parameter int W = DCT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [$clog2(N)-1:0] i_wr_row,
  input  logic [N*W-1:0]       i_wr_data,
  input  logic                 i_mode,
  input  logic                 i_clr_full,
  input  logic [$clog2(N)-1:0] i_rd_idx,
  output logic                 o_full,
  output logic [N*W-1:0]       o_rd_data
);

  localparam int RW = $clog2(N);

  logic [W-1:0] r_mem [N][N];
  logic         r_full;
  logic         r_mode;

  wire w_last_row = (i_wr_row == RW'(N - 1));

  // Storage is deliberately not reset: a block is only readable once the
  // full flag is set, and that flag is cleared by reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < N; k++) begin
        r_mem[i_wr_row][k] <= i_wr_data[k*W +: W];
      end
    end
  end

  // Setting and clearing never coincide: a write needs the bank empty,
  // a clear needs it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_mode <= MODE_TRANSPOSE;
    end else begin
      if (i_wr_en && (i_wr_row == '0)) begin
        r_mode <= i_mode;
      end
      if (i_wr_en && w_last_row) begin
        r_full <= 1'b1;
      end else if (i_clr_full) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;

  // Transpose: lane r of vector j is element (row r, lane j).
  // Bypass:    vector j is stored row j unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign o_rd_data[gi*W +: W] = (r_mode == MODE_BYPASS) ? r_mem[i_rd_idx][gi]
                                                            : r_mem[gi][i_rd_idx];
    end
  endgenerate

endmodule

// File: rtl/dct_transpose_buffer.sv
// ----------------------------------------------------------------------------
// dct_transpose_buffer
// Ping-pong N x N transpose buffer between the row and column passes of a
// 2-D DCT. Rows are written into one bank while the other bank is drained as
// columns (transpose mode) or rows (bypass mode).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   en                  : global enable, low freezes all state
//   in_valid/in_ready   : input row handshake, in_data = N lanes of W bits
//   mode                : 0 transpose, 1 bypass; taken with row 0 of a block
//   out_valid/out_ready : output vector handshake, out_data = N lanes
//   out_last            : marks vector N-1 of a block
// ----------------------------------------------------------------------------
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int N = DCT_N,
  parameter int W = DCT_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_last
);

  localparam int RW = $clog2(N);

  bank_sel_t       r_wr_sel;
  bank_sel_t       r_rd_sel;
  logic [RW-1:0]   r_wr_row;
  logic [RW-1:0]   r_rd_idx;

  logic            w_full    [2];
  logic [N*W-1:0]  w_rd_data [2];
  logic            w_wr_en   [2];
  logic            w_clr     [2];

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_wr_last;
  logic            w_rd_last;

  // Gating with !reset keeps the handshakes quiet during the reset cycle,
  // before the bank flags have been cleared.
  assign w_in_ready  = en && !reset && !w_full[r_wr_sel];
  assign w_out_valid = en && !reset && w_full[r_rd_sel];
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;
  assign w_wr_last   = (r_wr_row == RW'(N - 1));
  assign w_rd_last   = (r_rd_idx == RW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_sel <= BANK_A;
      r_rd_sel <= BANK_A;
      r_wr_row <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_in_fire) begin
        r_wr_row <= w_wr_last ? '0 : r_wr_row + RW'(1);
        if (w_wr_last) begin
          r_wr_sel <= other_bank(r_wr_sel);
        end
      end
      if (w_out_fire) begin
        r_rd_idx <= w_rd_last ? '0 : r_rd_idx + RW'(1);
        if (w_rd_last) begin
          r_rd_sel <= other_bank(r_rd_sel);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam bank_sel_t SEL = (gi == 0) ? BANK_A : BANK_B;

      assign w_wr_en[gi] = w_in_fire && (r_wr_sel == SEL);
      assign w_clr[gi]   = w_out_fire && w_rd_last && (r_rd_sel == SEL);

      dct_tb_bank #(
        .N (N),
        .W (W)
      ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_wr_en[gi]),
        .i_wr_row   (r_wr_row),
        .i_wr_data  (in_data),
        .i_mode     (mode),
        .i_clr_full (w_clr[gi]),
        .i_rd_idx   (r_rd_idx),
        .o_full     (w_full[gi]),
        .o_rd_data  (w_rd_data[gi])
      );
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_rd_data[r_rd_sel];
  assign out_last  = w_out_valid && w_rd_last;

endmodule
